irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter N_SRC, default 4, meaning the number of interrupt sources (1..16).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h40000030, meaning the byte address of the register window (4 words).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its posedge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port src, input, N_SRC, peripheral event lines (timer, UART rx/tx, ...).
REQ-006 SHALL have port kernel, input, 1, CPU PC[31]: 1 = executing in kernel/handler space.
REQ-007 SHALL have ports MemRd and MemWr, input, 1 each, bus read and write strobes.
REQ-008 SHALL have ports Addr and WriteData, input, 32 each, bus address and write data.
REQ-009 SHALL have port ReadData, output, 32, read data; 0 when not selected.
REQ-010 SHALL have port irq, output, 1, level to the CPU Interrupt input.

Function
REQ-011 SHALL select the window when Addr[31:4]==BASE_ADDR[31:4]; offsets: 0x0 PEND, 0x4 MASK, 0x8 CAUSE, 0xC SET.
REQ-012 SHALL drive ReadData combinationally in the same cycle as MemRd; unused bits read 0; CAUSE = {valid, 26'b0, id[4:0]}.
REQ-013 SHALL register src and set PEND[i] on a 0->1 edge of src[i].
REQ-014 SHALL clear PEND bits written 1 at PEND (W1C), set PEND bits written 1 at SET (W1S), and write MASK directly; each write takes effect at the posedge of the MemWr cycle.
REQ-015 SHALL give set priority over clear when an edge and a W1C hit the same bit in the same cycle.
REQ-016 SHALL have FSM states IDLE, ASSERT and SERVICE, with irq=1 only in ASSERT.
REQ-017 IDLE->ASSERT SHALL occur when |(PEND&MASK) and kernel==0; the chosen id SHALL be latched into CAUSE with valid=1 on that transition.
REQ-018 ASSERT->SERVICE SHALL occur when kernel==1 is sampled; irq SHALL drop in the same posedge.
REQ-019 SHALL also take ASSERT->SERVICE when kernel rises because of an exception; PEND stays set so the event re-raises later.
REQ-020 SERVICE->IDLE SHALL occur when kernel==0 is sampled; CAUSE.valid SHALL clear on that transition.
REQ-021 SHALL keep ASSERT->SERVICE latency (kernel=1 to irq=0) at 1 cycle, and IDLE re-arm to irq=1 at 1 cycle after kernel=0 while a masked-in pending bit remains.
REQ-022 SHALL leave the FSM state unchanged on PEND or MASK writes made during ASSERT; CAUSE is not re-chosen.

Reset
REQ-023 SHALL, while reset==0 at posedge clk, set PEND=0, MASK=0, CAUSE=0, FSM=IDLE, irq=0, the src history to 0, and the RR pointer to 0.
REQ-024 SHALL abort any ASSERT or SERVICE state when reset is asserted mid-operation; no event SHALL be latched in the reset cycle.

Configuration
REQ-025 Macro IRQ_RR_EN: when defined, SHALL choose the winner round-robin, searching from (last granted id + 1) mod N_SRC.
REQ-026 When IRQ_RR_EN is undefined, SHALL use fixed priority, lowest index wins, with no pointer register.

Structure
REQ-027 Package irq_pkg SHALL hold the register offsets, the FSM state encoding and the N_SRC maximum.
REQ-028 Sub-module irq_pick SHALL be combinational, taking the request vector and the pointer and returning the id and a valid flag.

Verification
REQ-029 MASK=4'b0001 written, src[0] pulsed, kernel=0 -> PEND=1, irq=1 next cycle, CAUSE=0x80000000; kernel=1 -> irq=0 next cycle.
REQ-030 src[2] rises with MASK=0 -> PEND=4'b0100, irq stays 0; write MASK=4'b0100 -> irq=1, CAUSE=0x80000002.
REQ-031 PEND=4'b0110 with all masked in, fixed priority -> CAUSE id 1; W1C 4'b0010, kernel 1->0 -> re-arm with id 2.
REQ-032 With IRQ_RR_EN, sources 0 and 3 held pending and kernel toggled repeatedly -> ids granted 0,3,0,3.
REQ-033 W1C of bit 1 in the same cycle as a src[1] edge -> PEND[1]=1.
REQ-034 reset=0 for one cycle during ASSERT -> irq=0, PEND=0, MASK=0, CAUSE=0 next cycle.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM encoding and source limits.
package irq_pkg;

    localparam int N_SRC_MAX = 16;
    localparam int ID_W      = 5;
    localparam int PTR_W     = 4;

    localparam logic [3:0] OFF_PEND  = 4'h0;
    localparam logic [3:0] OFF_MASK  = 4'h4;
    localparam logic [3:0] OFF_CAUSE = 4'h8;
    localparam logic [3:0] OFF_SET   = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    function automatic logic [31:0] cause_word(input logic valid, input logic [ID_W-1:0] id);
        return {valid, 26'b0, id};
    endfunction

endpackage

// File: rtl/irq_pick.sv
// Combinational winner selection: first set request at or after ptr, wrapping to index 0.
module irq_pick
    import irq_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    always_comb begin
        id    = '0;
        valid = 1'b0;
        // Upper segment [ptr, N_SRC) first, then wrap around to the lower one.
        for (int i = 0; i < N_SRC; i++) begin
            if (!valid && req[i] && (i >= int'(ptr))) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (!valid && req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller with PEND/MASK/CAUSE/SET registers and an IDLE/ASSERT/SERVICE FSM.
// Define IRQ_RR_EN for round-robin winner selection; the default build uses fixed lowest-index priority.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h40000030
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic             kernel,
    input  logic             MemRd,
    input  logic             MemWr,
    input  logic [31:0]      Addr,
    input  logic [31:0]      WriteData,
    output logic [31:0]      ReadData,
    output logic             irq
);

    logic             sel;
    logic             wr_pend;
    logic             wr_mask;
    logic             wr_set;
    logic [N_SRC-1:0] wdata;
    logic [N_SRC-1:0] src_p0;
    logic [N_SRC-1:0] src_edge;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] pend_next;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] req;
    logic             cause_valid;
    logic [ID_W-1:0]  cause_id;
    logic [PTR_W-1:0] ptr;
    logic [ID_W-1:0]  pick_id;
    logic             pick_valid;
    logic             grant;
    irq_state_e       state;
    irq_state_e       state_next;
    logic             unused_wdata;

    assign sel     = (Addr[31:4] == BASE_ADDR[31:4]);
    assign wr_pend = MemWr && sel && (Addr[3:0] == OFF_PEND);
    assign wr_mask = MemWr && sel && (Addr[3:0] == OFF_MASK);
    assign wr_set  = MemWr && sel && (Addr[3:0] == OFF_SET);
    assign wdata   = WriteData[N_SRC-1:0];
    assign unused_wdata = ^WriteData;

    assign src_edge = src & ~src_p0;
    // Sets (edge or W1S) are ORed in after the W1C so a same-cycle edge wins.
    assign pend_next = (pend & ~(wr_pend ? wdata : '0)) | (wr_set ? wdata : '0) | src_edge;
    assign req       = pend & mask;

    irq_pick #(.N_SRC(N_SRC)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .id    (pick_id),
        .valid (pick_valid)
    );

`ifdef IRQ_RR_EN
    logic [PTR_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (pick_id == ID_W'(N_SRC - 1)) ? '0 : pick_id[PTR_W-1:0] + 1'b1;
        end
    end

    assign ptr = rr_ptr;
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        irq        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid && !kernel) begin
                    state_next = ST_ASSERT;
                    grant      = 1'b1;
                end
            end
            ST_ASSERT: begin
                irq = 1'b1;
                if (kernel) begin
                    state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (!kernel) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Register file and cause latch
    always_ff @(posedge clk) begin
        if (!reset) begin
            src_p0      <= '0;
            pend        <= '0;
            mask        <= '0;
            cause_valid <= 1'b0;
            cause_id    <= '0;
        end else begin
            src_p0 <= src;
            pend   <= pend_next;
            if (wr_mask) begin
                mask <= wdata;
            end
            if (grant) begin
                cause_valid <= 1'b1;
                cause_id    <= pick_id;
            end else if ((state == ST_SERVICE) && !kernel) begin
                cause_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        ReadData = '0;
        if (MemRd && sel) begin
            case (Addr[3:0])
                OFF_PEND:  ReadData = 32'(pend);
                OFF_MASK:  ReadData = 32'(mask);
                OFF_CAUSE: ReadData = cause_word(cause_valid, cause_id);
                default:   ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller; expected ids follow IRQ_RR_EN when it is defined.
module tb_irq_controller;

    localparam logic [31:0] BASE    = 32'h40000030;
    localparam logic [31:0] A_PEND  = BASE + 32'h0;
    localparam logic [31:0] A_MASK  = BASE + 32'h4;
    localparam logic [31:0] A_CAUSE = BASE + 32'h8;
    localparam logic [31:0] A_SET   = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src;
    logic        kernel;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rdata;
    logic [31:0] exp_rr [4];

    irq_controller #(.N_SRC(4), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .src       (src),
        .kernel    (kernel),
        .MemRd     (MemRd),
        .MemWr     (MemWr),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr      = a;
        WriteData = d;
        MemWr     = 1'b1;
        tick();
        MemWr     = 1'b0;
        WriteData = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Addr  = a;
        MemRd = 1'b1;
        #1;
        d     = ReadData;
        MemRd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
`ifdef IRQ_RR_EN
        exp_rr = '{32'h80000000, 32'h80000003, 32'h80000000, 32'h80000003};
`else
        exp_rr = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
`endif
        reset = 1'b0; src = '0; kernel = 1'b0;
        MemRd = 1'b0; MemWr = 1'b0; Addr = '0; WriteData = '0;
        tick(); tick();

        // Reset state
        check_eq("rst_irq", {31'b0, irq}, 32'h0);
        rd(A_PEND, rdata);  check_eq("rst_pend", rdata, 32'h0);
        rd(A_MASK, rdata);  check_eq("rst_mask", rdata, 32'h0);
        rd(A_CAUSE, rdata); check_eq("rst_cause", rdata, 32'h0);
        reset = 1'b1;
        tick();

        // Single source: edge, assert, service, W1C, return
        wr(A_MASK, 32'h1);
        rd(A_MASK, rdata);  check_eq("mask_rb", rdata, 32'h1);
        src = 4'b0001;
        tick();
        src = 4'b0000;
        rd(A_PEND, rdata);  check_eq("a_pend", rdata, 32'h1);
        check_eq("a_irq_lat", {31'b0, irq}, 32'h0);
        tick();
        check_eq("a_irq_up", {31'b0, irq}, 32'h1);
        rd(A_CAUSE, rdata); check_eq("a_cause", rdata, 32'h80000000);
        kernel = 1'b1;
        tick();
        check_eq("a_irq_drop", {31'b0, irq}, 32'h0);
        wr(A_PEND, 32'h1);
        rd(A_PEND, rdata);  check_eq("a_w1c", rdata, 32'h0);
        kernel = 1'b0;
        tick();
        rd(A_CAUSE, rdata); check_eq("a_cause_clr", rdata, 32'h0);
        tick();
        check_eq("a_irq_idle", {31'b0, irq}, 32'h0);

        // Masked pending, then unmask
        wr(A_MASK, 32'h0);
        src = 4'b0100;
        tick();
        src = 4'b0000;
        tick(); tick();
        rd(A_PEND, rdata);  check_eq("b_pend", rdata, 32'h4);
        check_eq("b_irq_masked", {31'b0, irq}, 32'h0);
        wr(A_MASK, 32'h4);
        tick();
        check_eq("b_irq_up", {31'b0, irq}, 32'h1);
        rd(A_CAUSE, rdata); check_eq("b_cause", rdata, 32'h80000002);
        kernel = 1'b1;
        tick();
        wr(A_PEND, 32'hF);
        kernel = 1'b0;
        tick(); tick();
        check_eq("b_irq_idle", {31'b0, irq}, 32'h0);

        // Priority among two pending, re-arm, writes during ASSERT
        wr(A_MASK, 32'hF);
        wr(A_SET, 32'h6);
        rd(A_PEND, rdata);  check_eq("c_pend_set", rdata, 32'h6);
        tick();
        check_eq("c_irq_up", {31'b0, irq}, 32'h1);
        rd(A_CAUSE, rdata); check_eq("c_cause1", rdata, 32'h80000001);
        kernel = 1'b1;
        tick();
        wr(A_PEND, 32'h2);
        kernel = 1'b0;
        tick();
        check_eq("c_irq_idle", {31'b0, irq}, 32'h0);
        tick();
        check_eq("c_rearm", {31'b0, irq}, 32'h1);
        rd(A_CAUSE, rdata); check_eq("c_cause2", rdata, 32'h80000002);
        wr(A_MASK, 32'h0);
        check_eq("c_hold_irq", {31'b0, irq}, 32'h1);
        rd(A_CAUSE, rdata); check_eq("c_hold_cause", rdata, 32'h80000002);
        kernel = 1'b1;
        tick();
        check_eq("c_irq_drop", {31'b0, irq}, 32'h0);
        wr(A_PEND, 32'hF);
        kernel = 1'b0;
        tick();

        // Edge beats a same-cycle W1C
        wr(A_SET, 32'h2);
        src = 4'b0010;
        wr(A_PEND, 32'h2);
        src = 4'b0000;
        rd(A_PEND, rdata);  check_eq("d_set_wins", rdata, 32'h2);
        wr(A_PEND, 32'h2);
        rd(A_PEND, rdata);  check_eq("d_w1c", rdata, 32'h0);

        // Unselected / idle bus reads
        rd(32'h40000040, rdata); check_eq("rd_unsel", rdata, 32'h0);
        Addr = A_MASK;
        #1;
        check_eq("rd_no_strobe", ReadData, 32'h0);

        // Two held sources, repeated handler entries
        reset = 1'b0;
        tick();
        reset = 1'b1;
        wr(A_MASK, 32'h9);
        wr(A_SET, 32'h9);
        for (int g = 0; g < 4; g++) begin
            tick();
            check_eq($sformatf("e_irq%0d", g), {31'b0, irq}, 32'h1);
            rd(A_CAUSE, rdata);
            check_eq($sformatf("e_cause%0d", g), rdata, exp_rr[g]);
            kernel = 1'b1;
            tick();
            kernel = 1'b0;
            tick();
        end
        rd(A_PEND, rdata);  check_eq("e_pend_kept", rdata, 32'h9);

        // Reset during ASSERT
        tick();
        check_eq("f_irq_up", {31'b0, irq}, 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("f_irq", {31'b0, irq}, 32'h0);
        rd(A_PEND, rdata);  check_eq("f_pend", rdata, 32'h0);
        rd(A_MASK, rdata);  check_eq("f_mask", rdata, 32'h0);
        rd(A_CAUSE, rdata); check_eq("f_cause", rdata, 32'h0);
        tick();
        check_eq("f_irq_after", {31'b0, irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
